// File: rtl/vend_change_dispenser_if.sv
// Change-dispenser bus: request side from the vend controller, coin/ack handshake
// toward the coin-return mechanism, plus status.
//   req, amount              change request (amount in nickel units)
//   dime_empty, nickel_empty tube status from the mechanism
//   mech_ack                 mechanism accepted the presented coin
//   coin                     00 none, 01 nickel, 10 dime
//   busy, done, err          status; remaining = nickel units still owed
interface vend_change_dispenser_if #(
  parameter int unsigned AMT_W = 4
);
  logic             req;
  logic [AMT_W-1:0] amount;
  logic             dime_empty;
  logic             nickel_empty;
  logic             mech_ack;
  logic [1:0]       coin;
  logic             busy;
  logic             done;
  logic             err;
  logic [AMT_W-1:0] remaining;

  // Environment side (controller + mechanism).
  modport master (
    output req, amount, dime_empty, nickel_empty, mech_ack,
    input  coin, busy, done, err, remaining
  );

  // Dispenser side.
  modport slave (
    input  req, amount, dime_empty, nickel_empty, mech_ack,
    output coin, busy, done, err, remaining
  );
endinterface

// File: rtl/vend_change_dispenser.sv
// Change dispenser: pays an amount (nickel units) as dimes first, then nickels,
// one coin per valid/ack handshake, with an idle gap between coins.
// Ports:
//   clock  system clock (rising edge)
//   reset  synchronous, active-high
//   bus    vend_change_dispenser_if slave modport (request, tube flags, ack in;
//          coin, busy, done, err, remaining out). All outputs are registered.
module vend_change_dispenser #(
  parameter int unsigned AMT_W       = 4,
  parameter int unsigned GAP_CYCLES  = 1,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input logic                    clock,
  input logic                    reset,
  vend_change_dispenser_if.slave bus
);

  localparam logic [1:0] CoinNone   = 2'b00;
  localparam logic [1:0] CoinNickel = 2'b01;
  localparam logic [1:0] CoinDime   = 2'b10;

  localparam logic [7:0] ToLast  = 8'(ACK_TIMEOUT - 1);
  localparam logic [2:0] GapLast = 3'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StIssue, StGap, StDone, StErr} state_e;

  state_e           state_q, state_d;
  logic [1:0]       coin_q, coin_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [AMT_W-1:0] remaining_q, remaining_d;
  logic [7:0]       to_q, to_d;
  logic [2:0]       gap_q, gap_d;

  logic [1:0]       pick_idle, pick_gap;
  logic [AMT_W-1:0] rem_after_ack;

  // Dime only when at least two units are owed, so remaining never underflows.
  function automatic logic [1:0] pick_coin(logic [AMT_W-1:0] rem, logic no_dime,
                                           logic no_nickel);
    if (rem > AMT_W'(1) && !no_dime) return CoinDime;
    if (!no_nickel) return CoinNickel;
    return CoinNone;
  endfunction

  assign pick_idle     = pick_coin(bus.amount, bus.dime_empty, bus.nickel_empty);
  assign pick_gap      = pick_coin(remaining_q, bus.dime_empty, bus.nickel_empty);
  assign rem_after_ack = remaining_q - ((coin_q == CoinDime) ? AMT_W'(2) : AMT_W'(1));

  always_comb begin
    state_d     = state_q;
    coin_d      = CoinNone;
    done_d      = 1'b0;
    remaining_d = remaining_q;
    to_d        = to_q;
    gap_d       = gap_q;

    case (state_q)
      StIdle: begin
        if (bus.req) begin
          if (bus.amount == '0) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            remaining_d = bus.amount;
            to_d        = '0;
            if (pick_idle == CoinNone) begin
              state_d = StErr;
            end else begin
              state_d = StIssue;
              coin_d  = pick_idle;
            end
          end
        end
      end
      StIssue: begin
        // Ack takes priority over a timeout expiring in the same cycle.
        if (bus.mech_ack) begin
          remaining_d = rem_after_ack;
          if (rem_after_ack == '0) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            state_d = StGap;
            gap_d   = '0;
          end
        end else if (to_q == ToLast) begin
          state_d = StErr;
        end else begin
          coin_d = coin_q;
          to_d   = to_q + 8'd1;
        end
      end
      StGap: begin
        if (gap_q == GapLast) begin
          to_d = '0;
          if (pick_gap == CoinNone) begin
            state_d = StErr;
          end else begin
            state_d = StIssue;
            coin_d  = pick_gap;
          end
        end else begin
          gap_d = gap_q + 3'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      StErr: begin
        state_d = StErr;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
    err_d  = (state_d == StErr);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      coin_q      <= CoinNone;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      remaining_q <= '0;
      to_q        <= '0;
      gap_q       <= '0;
    end else begin
      state_q     <= state_d;
      coin_q      <= coin_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      remaining_q <= remaining_d;
      to_q        <= to_d;
      gap_q       <= gap_d;
    end
  end

  assign bus.coin      = coin_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.remaining = remaining_q;

endmodule
